// File: rtl/obi_ahb_bridge_pkg.sv
// Shared AHB-Lite encodings and bridge FSM states used by the OBI-to-AHB bridge
// and its beat splitter.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XFER,
    ST_LAST,
    ST_ERR2,
    ST_RESP
  } bridgeState_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

endpackage

// File: rtl/obi_ahb_bridge_if.sv
// Core-side request/response signals plus the AHB-Lite master bus, seen from the
// bridge (master modport) or from the surrounding core and slave (slave modport).
interface obi_ahb_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import ahb_pkg::*;

  localparam int NB = DATA_WIDTH / 8;

  logic                  req_i;
  logic                  we_i;
  logic [NB-1:0]         be_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  gnt_o;
  logic                  rvalid_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  err_o;

  logic                  hsel_o;
  logic [ADDR_WIDTH-1:0] haddr_o;
  logic [DATA_WIDTH-1:0] hwdata_o;
  logic                  hwrite_o;
  hsize_t                hsize_o;
  logic [2:0]            hburst_o;
  logic [3:0]            hprot_o;
  htrans_t               htrans_o;
  logic                  hmastlock_o;
  logic                  hready_o;
  logic [DATA_WIDTH-1:0] hrdata_i;
  logic                  hreadyout_i;
  logic                  hresp_i;

  modport master (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o,
    output hsel_o, haddr_o, hwdata_o, hwrite_o, hsize_o, hburst_o, hprot_o,
    output htrans_o, hmastlock_o, hready_o,
    input  hrdata_i, hreadyout_i, hresp_i
  );

  modport slave (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o,
    input  hsel_o, haddr_o, hwdata_o, hwrite_o, hsize_o, hburst_o, hprot_o,
    input  htrans_o, hmastlock_o, hready_o,
    output hrdata_i, hreadyout_i, hresp_i
  );

endinterface

// File: rtl/obi_ahb_bridge_split.sv
// Picks the next naturally aligned AHB beat out of a pending byte-lane mask:
// lowest set lane, widest aligned fully-enabled span starting there.
module be_beat_split import ahb_pkg::*; #(
  parameter int NB = 4
) (
  input  logic [NB-1:0]         pm_i,
  output logic [$clog2(NB)-1:0] offset_o,
  output hsize_t                size_o,
  output logic [NB-1:0]         mask_o
);

  localparam int OFF_W = $clog2(NB);

  int            offInt;
  int            sizeLog;
  logic [NB-1:0] span;

  // A wider span only qualifies if every narrower one did, so the last hit wins
  always_comb begin
    offInt  = 0;
    sizeLog = 0;
    span    = '0;
    mask_o  = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (pm_i[i]) offInt = i;
    end
    for (int j = 0; j < NB; j++) begin
      if (j == offInt) mask_o[j] = 1'b1;
    end
    for (int k = 1; (1 << k) <= NB; k++) begin
      span = '0;
      for (int j = 0; j < NB; j++) begin
        if (j >= offInt && j < offInt + (1 << k)) span[j] = 1'b1;
      end
      if ((offInt % (1 << k)) == 0 && (pm_i & span) == span) begin
        sizeLog = k;
        mask_o  = span;
      end
    end
    offset_o = OFF_W'(offInt);
    size_o   = hsize_t'(3'(sizeLog));
  end

endmodule

// File: rtl/obi_ahb_bridge.sv
// OBI (req/gnt/rvalid) to AHB-Lite master bridge: one outstanding request, split
// into aligned single beats with pipelined address/data and two-cycle ERROR handling.
module obi_ahb_bridge import ahb_pkg::*; #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
  input logic              clk,
  input logic              rst,
  obi_ahb_bridge_if.master bus
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);

  bridgeState_t                state_q, state_d;
  logic [ADDR_WIDTH-OFF_W-1:0] addrHi_q, addrHi_d;
  logic                        we_q, we_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]       hwdata_q, hwdata_d;
  logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
  logic [NB-1:0]               pm_q, pm_d;
  logic [NB-1:0]               dpMask_q, dpMask_d;
  logic                        dpValid_q, dpValid_d;
  logic                        err_q, err_d;

  logic [OFF_W-1:0]      beatOff;
  hsize_t                beatSize;
  logic [NB-1:0]         beatMask;
  logic [DATA_WIDTH-1:0] beatBits;
  logic [DATA_WIDTH-1:0] dpBits;
  logic [DATA_WIDTH-1:0] mergedRdata;
  logic                  hready;
  logic                  busErr;
  logic                  grant;
  logic                  addrLoUnused;

  be_beat_split #(.NB(NB)) u_split (
    .pm_i     (pm_q),
    .offset_o (beatOff),
    .size_o   (beatSize),
    .mask_o   (beatMask)
  );

  assign hready       = bus.hreadyout_i;
  assign busErr       = dpValid_q && bus.hresp_i && !bus.hreadyout_i;
  assign grant        = bus.req_i && (state_q == ST_IDLE);
  assign addrLoUnused = ^bus.addr_i[OFF_W-1:0];

  always_comb begin
    beatBits = '0;
    dpBits   = '0;
    for (int i = 0; i < NB; i++) begin
      beatBits[i*8 +: 8] = {8{beatMask[i]}};
      dpBits[i*8 +: 8]   = {8{dpMask_q[i]}};
    end
    mergedRdata = (rdata_q & ~dpBits) | (bus.hrdata_i & dpBits);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addrHi_q  <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      hwdata_q  <= '0;
      rdata_q   <= '0;
      pm_q      <= '0;
      dpMask_q  <= '0;
      dpValid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addrHi_q  <= addrHi_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      hwdata_q  <= hwdata_d;
      rdata_q   <= rdata_d;
      pm_q      <= pm_d;
      dpMask_q  <= dpMask_d;
      dpValid_q <= dpValid_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addrHi_d  = addrHi_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    hwdata_d  = hwdata_q;
    rdata_d   = rdata_q;
    pm_d      = pm_q;
    dpMask_d  = dpMask_q;
    dpValid_d = dpValid_q;
    err_d     = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d   = ST_XFER;
          addrHi_d  = bus.addr_i[ADDR_WIDTH-1:OFF_W];
          we_d      = bus.we_i;
          wdata_d   = bus.wdata_i;
          pm_d      = (bus.be_i == '0) ? '1 : bus.be_i;
          rdata_d   = '0;
          err_d     = 1'b0;
          dpValid_d = 1'b0;
        end
      end
      // Address phase of the current beat overlaps the data phase of the previous one
      ST_XFER: begin
        if (busErr) begin
          state_d = ST_ERR2;
          err_d   = 1'b1;
        end else if (hready) begin
          if (dpValid_q && !we_q) rdata_d = mergedRdata;
          pm_d      = pm_q & ~beatMask;
          dpValid_d = 1'b1;
          dpMask_d  = beatMask;
          hwdata_d  = wdata_q & beatBits;
          if ((pm_q & ~beatMask) == '0) state_d = ST_LAST;
        end
      end
      ST_LAST: begin
        if (busErr) begin
          state_d = ST_ERR2;
          err_d   = 1'b1;
        end else if (hready) begin
          if (!we_q) rdata_d = mergedRdata;
          dpValid_d = 1'b0;
          state_d   = ST_RESP;
        end
      end
      ST_ERR2: begin
        if (hready) begin
          dpValid_d = 1'b0;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NONSEQ is withdrawn in the first ERROR cycle so the pending beat is never issued
  always_comb begin
    bus.gnt_o       = grant;
    bus.rvalid_o    = (state_q == ST_RESP);
    bus.err_o       = (state_q == ST_RESP) && err_q;
    bus.rdata_o     = rdata_q;
    bus.hsel_o      = (state_q == ST_XFER) || (state_q == ST_LAST) || (state_q == ST_ERR2);
    bus.htrans_o    = (state_q == ST_XFER && !busErr) ? HTRANS_NONSEQ : HTRANS_IDLE;
    bus.haddr_o     = {addrHi_q, beatOff};
    bus.hsize_o     = beatSize;
    bus.hwrite_o    = we_q;
    bus.hwdata_o    = hwdata_q;
    bus.hburst_o    = HBURST_SINGLE;
    bus.hprot_o     = HPROT_VAL;
    bus.hmastlock_o = 1'b0;
    bus.hready_o    = hready;
  end

endmodule

// File: tb/tb_obi_ahb_bridge.sv
// Self-checking bench for obi_ahb_bridge: table of aligned/split transfers plus
// hand-driven wait-state, ERROR and mid-transfer reset sequences.
module tb_obi_ahb_bridge;
  import ahb_pkg::*;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] hrd;
    logic [31:0] rdata;
    int          nBeats;
    logic [31:0] a0;
    logic [2:0]  s0;
    logic [31:0] w0;
    logic [31:0] a1;
    logic [2:0]  s1;
    logic [31:0] w1;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chkData;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        write;
  } beat_t;

  localparam int BUDGET = 30;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;
  logic dpPend;

  exp_t        scoreQ[$];
  beat_t       aBeatQ[$];
  logic [31:0] wBeatQ[$];
  vec_t        vecs[8];

  obi_ahb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  obi_ahb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .HPROT_VAL(4'b0011)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record accepted address phases and completed data phases at mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      dpPend <= 1'b0;
    end else if (bus.hreadyout_i) begin
      if (dpPend) wBeatQ.push_back(bus.hwdata_o);
      if (bus.htrans_o == HTRANS_NONSEQ)
        aBeatQ.push_back('{addr: bus.haddr_o, size: bus.hsize_o, write: bus.hwrite_o});
      dpPend <= (bus.htrans_o == HTRANS_NONSEQ);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one request in an IDLE cycle and queue its expected response
  task automatic applyStimulus(input vec_t v, input logic expErr, input int expLat);
    @(posedge clk); #1;
    aBeatQ.delete();
    wBeatQ.delete();
    bus.req_i       = 1'b1;
    bus.we_i        = v.we;
    bus.be_i        = v.be;
    bus.addr_i      = v.addr;
    bus.wdata_i     = v.wdata;
    bus.hrdata_i    = v.hrd;
    bus.hreadyout_i = 1'b1;
    bus.hresp_i     = 1'b0;
    scoreQ.push_back('{rdata: v.rdata, err: expErr, chkData: !v.we && !expErr, lat: expLat});
    @(negedge clk);
    checkOutput("gnt", bus.gnt_o, 1);
    @(posedge clk); #1;
    bus.req_i = 1'b0;
  endtask

  // Step cycles with a per-cycle hready/hresp schedule until rvalid, then score it
  task automatic runResp(input logic [31:0] rdyN, input logic [31:0] rsp,
                         input logic [31:0] heldAddr, input logic [2:0] heldSize);
    logic got;
    exp_t e;
    got = 1'b0;
    for (int c = 1; c <= BUDGET; c++) begin
      bus.hreadyout_i = !rdyN[c];
      bus.hresp_i     = rsp[c];
      @(negedge clk);
      if (rsp[c]) begin
        checkOutput("errHtransIdle", bus.htrans_o, HTRANS_IDLE);
      end else if (rdyN[c]) begin
        checkOutput("waitHaddr", bus.haddr_o, heldAddr);
        checkOutput("waitHsize", bus.hsize_o, heldSize);
        checkOutput("waitHtrans", bus.htrans_o, HTRANS_NONSEQ);
        checkOutput("waitHready", bus.hready_o, 0);
      end
      if (bus.rvalid_o) begin
        got = 1'b1;
        checkOutput("sbHasEntry", scoreQ.size() != 0, 1);
        if (scoreQ.size() != 0) begin
          e = scoreQ.pop_front();
          checkOutput("latency", c, e.lat);
          checkOutput("errO", bus.err_o, e.err);
          if (e.chkData) checkOutput("rdata", bus.rdata_o, e.rdata);
        end
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("rvalidSeen", got, 1);
    bus.hreadyout_i = 1'b1;
    bus.hresp_i     = 1'b0;
  endtask

  task automatic checkBeats(input vec_t v, input int idx);
    logic [31:0] expA;
    logic [2:0]  expS;
    logic [31:0] expW;
    checkOutput($sformatf("v%0d.beatCount", idx), aBeatQ.size(), v.nBeats);
    checkOutput($sformatf("v%0d.dataCount", idx), wBeatQ.size(), v.nBeats);
    for (int b = 0; b < v.nBeats && b < aBeatQ.size(); b++) begin
      expA = (b == 0) ? v.a0 : v.a1;
      expS = (b == 0) ? v.s0 : v.s1;
      expW = (b == 0) ? v.w0 : v.w1;
      checkOutput($sformatf("v%0d.b%0d.haddr", idx, b), aBeatQ[b].addr, expA);
      checkOutput($sformatf("v%0d.b%0d.hsize", idx, b), aBeatQ[b].size, expS);
      checkOutput($sformatf("v%0d.b%0d.hwrite", idx, b), aBeatQ[b].write, v.we);
      if (v.we && b < wBeatQ.size())
        checkOutput($sformatf("v%0d.b%0d.hwdata", idx, b), wBeatQ[b], expW);
    end
  endtask

  initial begin
    vec_t vErr;
    vec_t vWait;
    vec_t vRst;
    testsRun    = 0;
    testsFailed = 0;

    //          we    be       addr    wdata         hrd           rdata      n  a0      s0  w0            a1      s1  w1
    vecs[0] = '{1'b0, 4'b1111, 'h100, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1, 'h100, 2, 32'h0,        'h0,    0, 32'h0};
    vecs[1] = '{1'b1, 4'b0101, 'h200, 32'hAABBCCDD, 32'h0,        32'h0,        2, 'h200, 0, 32'h000000DD, 'h202,  0, 32'h00BB0000};
    vecs[2] = '{1'b0, 4'b1110, 'h040, 32'h0,        32'h11223344, 32'h11223300, 2, 'h041, 0, 32'h0,        'h042,  1, 32'h0};
    vecs[3] = '{1'b1, 4'b0000, 'h080, 32'h12345678, 32'h0,        32'h0,        1, 'h080, 2, 32'h12345678, 'h0,    0, 32'h0};
    vecs[4] = '{1'b0, 4'b1100, 'h013, 32'h0,        32'h55667788, 32'h55660000, 1, 'h012, 1, 32'h0,        'h0,    0, 32'h0};
    vecs[5] = '{1'b1, 4'b0111, 'h020, 32'hA1B2C3D4, 32'h0,        32'h0,        2, 'h020, 1, 32'h0000C3D4, 'h022,  0, 32'h00B20000};
    vecs[6] = '{1'b0, 4'b1000, 'h07C, 32'h0,        32'h9ABCDEF0, 32'h9A000000, 1, 'h07F, 0, 32'h0,        'h0,    0, 32'h0};
    vecs[7] = '{1'b0, 4'b1011, 'h030, 32'h0,        32'h01020304, 32'h01000304, 2, 'h030, 1, 32'h0,        'h033,  0, 32'h0};

    vWait = '{1'b0, 4'b0011, 'h000, 32'h0, 32'hCAFEBABE, 32'h0000BABE, 1, 'h000, 1, 32'h0, 'h0, 0, 32'h0};
    vErr  = '{1'b0, 4'b1001, 'h400, 32'h0, 32'h77777777, 32'h0,        1, 'h400, 0, 32'h0, 'h0, 0, 32'h0};
    vRst  = '{1'b0, 4'b1111, 'h300, 32'h0, 32'h13572468, 32'h13572468, 1, 'h300, 2, 32'h0, 'h0, 0, 32'h0};

    bus.req_i       = 1'b0;
    bus.we_i        = 1'b0;
    bus.be_i        = '0;
    bus.addr_i      = '0;
    bus.wdata_i     = '0;
    bus.hrdata_i    = '0;
    bus.hreadyout_i = 1'b1;
    bus.hresp_i     = 1'b0;
    rst             = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst.gnt", bus.gnt_o, 0);
    checkOutput("rst.rvalid", bus.rvalid_o, 0);
    checkOutput("rst.err", bus.err_o, 0);
    checkOutput("rst.rdata", bus.rdata_o, 0);
    checkOutput("rst.htrans", bus.htrans_o, HTRANS_IDLE);
    checkOutput("rst.hsel", bus.hsel_o, 0);
    checkOutput("rst.haddr", bus.haddr_o, 0);
    checkOutput("rst.hwdata", bus.hwdata_o, 0);
    checkOutput("rst.hwrite", bus.hwrite_o, 0);
    checkOutput("rst.hsize", bus.hsize_o, 0);
    checkOutput("rst.hburst", bus.hburst_o, 3'b000);
    checkOutput("rst.hprot", bus.hprot_o, 4'b0011);
    checkOutput("rst.hmastlock", bus.hmastlock_o, 0);
    checkOutput("rst.hready", bus.hready_o, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], 1'b0, 2 + vecs[i].nBeats);
      runResp('0, '0, '0, '0);
      checkBeats(vecs[i], i);
    end

    // Beat 1 address phase stalled for two cycles
    applyStimulus(vWait, 1'b0, 5);
    runResp(32'b0110, '0, 32'h0, HSIZE_HALF);
    checkBeats(vWait, 8);

    // ERROR on beat 1 data phase: second beat must never be issued
    applyStimulus(vErr, 1'b1, 4);
    runResp(32'b0100, 32'b1100, '0, '0);
    checkOutput("err.beatCount", aBeatQ.size(), 1);

    // Reset while the first address phase is held
    applyStimulus(vRst, 1'b0, 3);
    bus.hreadyout_i = 1'b0;
    @(negedge clk);
    checkOutput("rstMid.preHtrans", bus.htrans_o, HTRANS_NONSEQ);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst             = 1'b0;
    bus.hreadyout_i = 1'b1;
    @(negedge clk);
    checkOutput("rstMid.htrans", bus.htrans_o, HTRANS_IDLE);
    checkOutput("rstMid.gnt", bus.gnt_o, 0);
    checkOutput("rstMid.hsel", bus.hsel_o, 0);
    checkOutput("rstMid.rvalid", bus.rvalid_o, 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("rstMid.noRvalid", bus.rvalid_o, 0);
    end
    // The abandoned request never responds, so drop its scoreboard entry
    if (scoreQ.size() != 0) void'(scoreQ.pop_front());

    applyStimulus(vRst, 1'b0, 3);
    runResp('0, '0, '0, '0);
    checkBeats(vRst, 9);

    checkOutput("sbDrained", scoreQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
